// File: rtl/saturation_correction_power_stage.sv
// Exponent-term feeder for SRSC saturation correction: Ac^0.3 (Q3.7) per A update via a load FSM,
// and Jc^0.7 (Q6.4) streamed per pixel through a 2-stage valid/ready pipeline.
module saturation_correction_power_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_load_i,
    input  logic [7:0] a_r_i,
    input  logic [7:0] a_g_i,
    input  logic [7:0] a_b_i,
    output logic       a_busy_o,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic [7:0] j_r_i,
    input  logic [7:0] j_g_i,
    input  logic [7:0] j_b_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic [9:0] ac_r_o,
    output logic [9:0] ac_g_o,
    output logic [9:0] ac_b_o,
    output logic [9:0] jc_r_o,
    output logic [9:0] jc_g_o,
    output logic [9:0] jc_b_o
);

    function automatic logic [127:0] pow10(input logic [127:0] x);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < 10; i++) p = p * x;
        return p;
    endfunction

    // Largest y in 0..1023 with (2y-1)^10 <= t, i.e. round(t^(1/10) / 2), saturating at 1023.
    function automatic logic [9:0] round_root10(input logic [127:0] t);
        int lo, hi, mid;
        lo = 0;
        hi = 1023;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (pow10(128'(2 * mid - 1)) <= t) lo = mid;
            else hi = mid - 1;
        end
        return 10'(lo);
    endfunction

    // A table: (2x)^10 = k^3 * 2^80 for x = k^0.3*128; J table: (2x)^10 = k^7 * 2^50 for x = k^0.7*16.
    function automatic logic [2559:0] gen_rom(input logic is_j);
        logic [2559:0] rom;
        logic [127:0]  k, t;
        rom = '0;
        for (int i = 0; i < 256; i++) begin
            k = 128'(i);
            t = is_j ? ((k * k * k * k * k * k * k) << 50) : ((k * k * k) << 80);
            rom[i*10 +: 10] = round_root10(t);
        end
        return rom;
    endfunction

    localparam logic [2559:0] A_ROM = gen_rom(1'b0);
    localparam logic [2559:0] J_ROM = gen_rom(1'b1);

    logic [9:0] a_rom [256];
    logic [9:0] j_rom [256];
    for (genvar k = 0; k < 256; k++) begin : g_rom
        assign a_rom[k] = A_ROM[k*10 +: 10];
        assign j_rom[k] = J_ROM[k*10 +: 10];
    end

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RUN} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       a_pend_q, a_pend_d;
    logic [7:0] ahold_r_q, ahold_g_q, ahold_b_q;
    logic [7:0] alat_r_q, alat_g_q, alat_b_q;
    logic [9:0] apow_r_q, apow_g_q, apow_b_q;
    logic [9:0] a_rom_q;
    logic [7:0] a_addr;
    logic       v1_q, v2_q;
    logic [9:0] jrd_r_q, jrd_g_q, jrd_b_q;
    logic [9:0] ac_r_q, ac_g_q, ac_b_q;
    logic [9:0] jc_r_q, jc_g_q, jc_b_q;
    logic       en, accept, enter_load;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_pend_q) state_d = LOAD;
            RUN:     if (a_pend_q) state_d = DRAIN;
            DRAIN:   if (!v1_q && !v2_q) state_d = LOAD;
            LOAD:    if (cnt_q == 2'd3) state_d = a_pend_q ? DRAIN : RUN;
            default: state_d = IDLE;
        endcase
    end

    assign enter_load = (state_d == LOAD) && (state_q != LOAD);
    assign cnt_d      = (state_q == LOAD) ? cnt_q + 2'd1 : 2'd0;
    // A pulse coinciding with LOAD entry keeps the request pending so the newer A is loaded next.
    assign a_pend_d   = a_load_i | (a_pend_q & ~enter_load);

    assign en        = !v2_q || m_ready_i;
    assign s_ready_o = (state_q == RUN) && !a_pend_q && en;
    assign accept    = s_valid_i && s_ready_o;
    assign a_busy_o  = a_pend_q || (state_q == DRAIN) || (state_q == LOAD);

    always_comb begin
        a_addr = alat_b_q;
        case (cnt_q)
            2'd0:    a_addr = alat_r_q;
            2'd1:    a_addr = alat_g_q;
            default: a_addr = alat_b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            a_pend_q  <= 1'b0;
            ahold_r_q <= '0;
            ahold_g_q <= '0;
            ahold_b_q <= '0;
            alat_r_q  <= '0;
            alat_g_q  <= '0;
            alat_b_q  <= '0;
            apow_r_q  <= '0;
            apow_g_q  <= '0;
            apow_b_q  <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            ac_r_q    <= '0;
            ac_g_q    <= '0;
            ac_b_q    <= '0;
            jc_r_q    <= '0;
            jc_g_q    <= '0;
            jc_b_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_pend_q <= a_pend_d;
            if (a_load_i) begin
                ahold_r_q <= a_r_i;
                ahold_g_q <= a_g_i;
                ahold_b_q <= a_b_i;
            end
            if (enter_load) begin
                alat_r_q <= ahold_r_q;
                alat_g_q <= ahold_g_q;
                alat_b_q <= ahold_b_q;
            end
            // ROM data for the address issued in LOAD cycle n lands in cycle n+1.
            if (state_q == LOAD) begin
                case (cnt_q)
                    2'd1:    apow_r_q <= a_rom_q;
                    2'd2:    apow_g_q <= a_rom_q;
                    2'd3:    apow_b_q <= a_rom_q;
                    default: ;
                endcase
            end
            if (en) begin
                v1_q   <= accept;
                v2_q   <= v1_q;
                ac_r_q <= apow_r_q;
                ac_g_q <= apow_g_q;
                ac_b_q <= apow_b_q;
                jc_r_q <= jrd_r_q;
                jc_g_q <= jrd_g_q;
                jc_b_q <= jrd_b_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        a_rom_q <= a_rom[a_addr];
        if (accept) begin
            jrd_r_q <= j_rom[j_r_i];
            jrd_g_q <= j_rom[j_g_i];
            jrd_b_q <= j_rom[j_b_i];
        end
    end

    assign m_valid_o = v2_q;
    assign ac_r_o    = ac_r_q;
    assign ac_g_o    = ac_g_q;
    assign ac_b_o    = ac_b_q;
    assign jc_r_o    = jc_r_q;
    assign jc_g_o    = jc_g_q;
    assign jc_b_o    = jc_b_q;

endmodule

// File: tb/tb_saturation_correction_power_stage.sv
// Directed/randomized bench: a real-arithmetic power model feeds a scoreboard of expected beats.
module tb_saturation_correction_power_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_load = 1'b0;
    logic [7:0] a_r = '0, a_g = '0, a_b = '0;
    logic       a_busy;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] j_r = '0, j_g = '0, j_b = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [9:0] ac_r, ac_g, ac_b, jc_r, jc_g, jc_b;

    saturation_correction_power_stage dut (
        .clk(clk), .rst_n(rst_n),
        .a_load_i(a_load), .a_r_i(a_r), .a_g_i(a_g), .a_b_i(a_b), .a_busy_o(a_busy),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .j_r_i(j_r), .j_g_i(j_g), .j_b_i(j_b),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .ac_r_o(ac_r), .ac_g_o(ac_g), .ac_b_o(ac_b),
        .jc_r_o(jc_r), .jc_g_o(jc_g), .jc_b_o(jc_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [9:0] ar, ag, ab, jr, jg, jb;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_e;
    logic [7:0] cur_r = '0, cur_g = '0, cur_b = '0;
    bit         log_lat = 1'b0;
    int         acc_cyc[$];
    int         pop_cyc[$];

    function automatic logic [9:0] ref_pow(input logic [7:0] k, input real e, input real scale);
        real x;
        int  y;
        x = $pow(real'(k), e) * scale;
        y = int'($floor(x + 0.5));
        if (y > 1023) y = 1023;
        return 10'(y);
    endfunction

    function automatic logic [9:0] apow(input logic [7:0] k);
        return ref_pow(k, 0.3, 128.0);
    endfunction

    function automatic logic [9:0] jpow(input logic [7:0] k);
        return ref_pow(k, 0.7, 16.0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: a beat carries the A-power of the last a_load preceding its acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (s_valid && s_ready) begin
                exp_q.push_back('{apow(cur_r), apow(cur_g), apow(cur_b), jpow(j_r), jpow(j_g), jpow(j_b)});
                if (log_lat) acc_cyc.push_back(cyc);
            end
            if (a_load) begin
                cur_r = a_r;
                cur_g = a_g;
                cur_b = a_b;
            end
            if (m_valid && m_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("ac_r", ac_r, mon_e.ar);
                    chk("ac_g", ac_g, mon_e.ag);
                    chk("ac_b", ac_b, mon_e.ab);
                    chk("jc_r", jc_r, mon_e.jr);
                    chk("jc_g", jc_g, mon_e.jg);
                    chk("jc_b", jc_b, mon_e.jb);
                    if (log_lat) pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        a_r = r; a_g = g; a_b = b;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (a_busy && n < 100) begin step(); n++; end
        chk("a_busy_clears", a_busy, 0);
    endtask

    task automatic wait_mvalid();
        int n = 0;
        while (!m_valid && n < 50) begin step(); n++; end
        chk("m_valid_arrives", m_valid, 1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin step(); n++; end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n = 0;
        j_r = r; j_g = g; j_b = b;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_accepted", s_ready, 1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_rnd();
        send(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        logic [7:0] r2, g2, b2;
        m_ready = 1'b1;
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_ac_r", ac_r, 0);
        chk("rst_jc_b", jc_b, 0);
        rst_n = 1'b1;
        step();
        chk("idle_s_ready", s_ready, 0);

        // Full-scale A and the 255/1/0 pixel corner values.
        load_a(8'd255, 8'd255, 8'd255);
        wait_idle();
        send(8'd255, 8'd1, 8'd0);
        wait_mvalid();
        chk("t1_ac_r", ac_r, 675);
        chk("t1_ac_b", ac_b, 675);
        chk("t1_jc_r", jc_r, 774);
        chk("t1_jc_g", jc_g, 16);
        chk("t1_jc_b", jc_b, 0);
        wait_empty();

        // Back-to-back stream with m_ready high: 2-cycle latency, no bubbles.
        log_lat = 1'b1;
        for (int i = 0; i < 16; i++) send_rnd();
        wait_empty();
        log_lat = 1'b0;
        chk("t2_beats", pop_cyc.size(), 16);
        for (int i = 0; i < 16 && i < pop_cyc.size() && i < acc_cyc.size(); i++) begin
            chk("t2_latency", 32'(pop_cyc[i] - acc_cyc[i]), 2);
            chk("t2_no_gap", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // Downstream backpressure toggling every cycle.
        fork
            for (int i = 0; i < 24; i++) send_rnd();
            for (int i = 0; i < 80; i++) begin step(); m_ready = ~m_ready; end
        join
        m_ready = 1'b1;
        wait_empty();

        // A update while the pipe is stalled full.
        m_ready = 1'b0;
        send_rnd();
        send_rnd();
        j_r = 8'd200; j_g = 8'd17; j_b = 8'd99;
        s_valid = 1'b1;
        a_r = 8'd128; a_g = 8'd128; a_b = 8'd128;
        a_load = 1'b1;
        @(negedge clk);
        chk("t4_s_ready_low", s_ready, 0);
        step();
        a_load = 1'b0;
        chk("t4_a_busy", a_busy, 1);
        m_ready = 1'b1;
        send(8'd200, 8'd17, 8'd99);
        wait_mvalid();
        chk("t4_ac_new", ac_r, apow(8'd128));
        chk("t4_jc", jc_g, jpow(8'd17));
        wait_empty();

        // Second A pulse arrives while the first is loading; last one wins.
        load_a(8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) begin
            chk("t5_a_busy_span", a_busy, 1);
            step();
        end
        r2 = 8'($urandom_range(1, 255));
        g2 = 8'($urandom_range(1, 255));
        b2 = 8'($urandom_range(1, 255));
        load_a(r2, g2, b2);
        chk("t5_a_busy_second", a_busy, 1);
        wait_idle();
        send_rnd();
        wait_mvalid();
        chk("t5_ac_r", ac_r, apow(r2));
        chk("t5_ac_g", ac_g, apow(g2));
        chk("t5_ac_b", ac_b, apow(b2));
        wait_empty();

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) send_rnd();
        s_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_a_busy", a_busy, 0);
        chk("t6_jc_r", jc_r, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_s_ready_idle", s_ready, 0);
        end
        step();
        load_a(8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle();
        @(negedge clk);
        chk("t6_s_ready_back", s_ready, 1);
        step();
        s_valid = 1'b0;
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
